vram_arbiter: RTL and testbench

Shares the single-port framebuffer RAM behind the GPU between three clients: the VGA scan-out fetch (client 0) and two draw engines (clients 1, 2). It accepts at most one request per cycle and issues a registered RAM command. Read data returns to the issuing client with fixed latency. It sits between the pixel pipeline/draw logic inside `gpu_driver` and the VRAM block RAM.

---
 rtl/vram_arb_pkg.sv | 30 +++
 rtl/vram_arbiter_rr_arb2.sv | 38 +++
 rtl/vram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: client indices, client-ID type and one-hot helpers shared by
// the VRAM arbiter and its round-robin sub-arbiter.
package vram_arb_pkg;

  localparam int NUM_CLI = 3;

  typedef logic [1:0] cli_id_t;

  localparam cli_id_t CLI_DISP = 2'd0;
  localparam cli_id_t CLI_DRW0 = 2'd1;
  localparam cli_id_t CLI_DRW1 = 2'd2;

  // One-hot client vector from a client ID; unused code 3 maps to no client.
  function automatic logic [NUM_CLI-1:0] id2oh(input cli_id_t id);
    case (id)
      CLI_DISP: id2oh = 3'b001;
      CLI_DRW0: id2oh = 3'b010;
      CLI_DRW1: id2oh = 3'b100;
      default:  id2oh = 3'b000;
    endcase
  endfunction

  // Client ID from a one-hot grant (grant is guaranteed one-hot or zero).
  function automatic cli_id_t oh2id(input logic [NUM_CLI-1:0] oh);
    if (oh[2])      oh2id = CLI_DRW1;
    else if (oh[1]) oh2id = CLI_DRW0;
    else            oh2id = CLI_DISP;
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter. rr=0 prefers input 0, rr=1 prefers
// input 1. The pointer moves past the winner only when upd is asserted, so a
// grant the parent overrides does not disturb fairness.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic rr_q, rr_d;

  // Grant the preferred input if it requests, otherwise the other one.
  always_comb begin
    gnt = 2'b00;
    if (!rr_q) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  // After a taken grant point at the input that lost.
  always_comb begin
    rr_d = rr_q;
    if (upd && (gnt != 2'b00)) rr_d = gnt[0];
  end

  // Pointer register; reset prefers input 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port framebuffer RAM between display
// scan-out (client 0, fixed top priority) and two draw engines (round-robin).
// One access per cycle, registered RAM command, 2-cycle read return.
// Optional build macro VRAM_ARB_STARVE_GUARD_EN: per-draw-client wait
// counters let a draw client that waited MAX_WAIT cycles outrank display.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 12,
  parameter int MAX_WAIT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CLI-1:0]        req,
  input  logic [NUM_CLI-1:0]        we,
  input  logic [NUM_CLI*ADDR_W-1:0] addr,
  input  logic [NUM_CLI*DATA_W-1:0] wdata,
  output logic [NUM_CLI-1:0]        gnt,
  output logic [NUM_CLI-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  logic [NUM_CLI-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_CLI-1:0][DATA_W-1:0] wdata_a;
  assign addr_a  = addr;
  assign wdata_a = wdata;

  // Display is read-only; its write enable is never looked at.
  logic unused_we0;
  assign unused_we0 = we[0];

  logic [NUM_CLI-1:0] gnt_c;
  logic [1:0]         starve, arb_req, arb_gnt;
  logic               arb_upd, disp_win;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [1:0][CW-1:0] wcnt_q, wcnt_d;

  // A draw client is starved while requesting with a saturated wait counter.
  always_comb begin
    starve = 2'b00;
    for (int k = 0; k < 2; k++)
      starve[k] = req[k+1] && (wcnt_q[k] == CW'(MAX_WAIT));
  end

  // Count cycles spent waiting; clear on grant or withdrawn request.
  always_comb begin
    wcnt_d = wcnt_q;
    for (int k = 0; k < 2; k++) begin
      if (!req[k+1] || gnt_c[k+1])          wcnt_d[k] = '0;
      else if (wcnt_q[k] != CW'(MAX_WAIT))  wcnt_d[k] = wcnt_q[k] + 1'b1;
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end
`else
  localparam int UNUSED_MAX_WAIT = MAX_WAIT;
  assign starve = 2'b00;
`endif

  // Starved draw clients compete among themselves; otherwise all draw requests.
  assign arb_req = (|starve) ? starve : req[2:1];

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .upd   (arb_upd),
    .gnt   (arb_gnt)
  );

  // Top-level grant: starvation override, then display, then round-robin.
  always_comb begin
    gnt_c    = '0;
    arb_upd  = 1'b0;
    disp_win = req[CLI_DISP] && !(|starve);
    if (rst_n) begin
      if (disp_win) begin
        gnt_c[CLI_DISP] = 1'b1;
      end else begin
        gnt_c[2:1] = arb_gnt;
        arb_upd    = |arb_gnt;
      end
    end
  end

  assign gnt = gnt_c;

  // Fields of the accepted request.
  logic              acc, we_sel;
  cli_id_t           id_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // Select the granted client's request fields (AND-OR mux over one-hot gnt).
  always_comb begin
    acc       = |gnt_c;
    id_sel    = oh2id(gnt_c);
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NUM_CLI; i++) begin
      if (gnt_c[i]) begin
        addr_sel  = addr_a[i];
        wdata_sel = wdata_a[i];
        we_sel    = (i != int'(CLI_DISP)) && we[i];
      end
    end
  end

  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:1]        vld_pipe_q, vld_pipe_d;
  cli_id_t [2:1]     id_pipe_q, id_pipe_d;

  // Next command stage and read-return pipeline; address/data hold when idle.
  always_comb begin
    mem_en_d      = acc;
    mem_we_d      = acc && we_sel;
    mem_addr_d    = acc ? addr_sel  : mem_addr_q;
    mem_wdata_d   = acc ? wdata_sel : mem_wdata_q;
    vld_pipe_d[1] = acc && !we_sel;
    id_pipe_d[1]  = id_sel;
    vld_pipe_d[2] = vld_pipe_q[1];
    id_pipe_d[2]  = id_pipe_q[1];
  end

  // Command and return-pipeline registers; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid    = vld_pipe_q[2] ? id2oh(id_pipe_q[2]) : '0;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: per-client request queues drive the arbiter; a reference
// model predicts grants and pushes expected RAM commands / read returns into
// scoreboard queues that a separate monitor pops and compares.
module tb_vram_arbiter;
  localparam int ADDR_W = 17, DATA_W = 12, MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] req = '0, we = '0;
  logic [3*ADDR_W-1:0] addr = '0;
  logic [3*DATA_W-1:0] wdata = '0;
  logic [2:0] gnt, rvalid;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM behind the arbiter: registered read, one-cycle latency.
  bit [DATA_W-1:0] ram[int];
  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    else mem_rdata <= ram[int'(mem_addr)];
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Client request queues.
  typedef struct { bit w; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } creq_t;
  creq_t cq0[$], cq1[$], cq2[$];
  int glog[$];

  task automatic push(input int c, input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    creq_t r;
    r.w = w; r.a = a; r.d = d;
    case (c)
      0: cq0.push_back(r);
      1: cq1.push_back(r);
      default: cq2.push_back(r);
    endcase
  endtask

  task automatic apply_heads();
    req = '0; we = '0;
    if (cq0.size() > 0) begin req[0] = 1; we[0] = cq0[0].w; addr[0 +: ADDR_W] = cq0[0].a; wdata[0 +: DATA_W] = cq0[0].d; end
    if (cq1.size() > 0) begin req[1] = 1; we[1] = cq1[0].w; addr[ADDR_W +: ADDR_W] = cq1[0].a; wdata[DATA_W +: DATA_W] = cq1[0].d; end
    if (cq2.size() > 0) begin req[2] = 1; we[2] = cq2[0].w; addr[2*ADDR_W +: ADDR_W] = cq2[0].a; wdata[2*DATA_W +: DATA_W] = cq2[0].d; end
  endtask

  // Clients: hold the head request until granted, then present the next one.
  initial begin : driver
    logic [2:0] g;
    forever begin
      @(negedge clk);
      g = gnt;
      if (g[0]) glog.push_back(0);
      if (g[1]) glog.push_back(1);
      if (g[2]) glog.push_back(2);
      @(posedge clk); #1;
      if (g[0]) void'(cq0.pop_front());
      if (g[1]) void'(cq1.pop_front());
      if (g[2]) void'(cq2.pop_front());
      apply_heads();
    end
  end

  // Reference model: rules of the arbitration applied to the visible requests.
  typedef struct { int due; bit w; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } cmd_t;
  typedef struct { int due; int id; logic [DATA_W-1:0] d; } rd_t;
  cmd_t cmdq[$];
  rd_t rdq[$];
  bit [DATA_W-1:0] shadow[int];
  int pref = 1;
  int wt1 = 0, wt2 = 0;

  always @(negedge clk) begin : model
    int win;
    bit s1, s2, w;
    logic [2:0] eg;
    cmd_t c;
    rd_t r;
    if (!rst_n) begin
      pref = 1; wt1 = 0; wt2 = 0;
    end else begin
`ifdef VRAM_ARB_STARVE_GUARD_EN
      s1 = req[1] && (wt1 == MAX_WAIT);
      s2 = req[2] && (wt2 == MAX_WAIT);
`else
      s1 = 0; s2 = 0;
`endif
      if (s1 || s2)                win = (s1 && s2) ? pref : (s1 ? 1 : 2);
      else if (req[0])             win = 0;
      else if (req[1] && req[2])   win = pref;
      else if (req[1])             win = 1;
      else if (req[2])             win = 2;
      else                         win = -1;
      eg = (win < 0) ? 3'b000 : 3'(1 << win);
      chk("gnt", 32'(gnt), 32'(eg));
      if (win >= 0) begin
        w = (win != 0) && we[win];
        c.due = cyc + 1; c.w = w;
        c.a = addr[win*ADDR_W +: ADDR_W];
        c.d = wdata[win*DATA_W +: DATA_W];
        cmdq.push_back(c);
        if (w) shadow[int'(c.a)] = c.d;
        else begin
          r.due = cyc + 2; r.id = win; r.d = shadow[int'(c.a)];
          rdq.push_back(r);
        end
      end
      if (win == 1) pref = 2;
      if (win == 2) pref = 1;
      wt1 = (!req[1] || win == 1) ? 0 : ((wt1 < MAX_WAIT) ? wt1 + 1 : wt1);
      wt2 = (!req[2] || win == 2) ? 0 : ((wt2 < MAX_WAIT) ? wt2 + 1 : wt2);
    end
  end

  // Monitor: compare RAM commands and read returns against the scoreboard.
  logic [ADDR_W-1:0] last_a = '0;
  always @(negedge clk) begin : monitor
    cmd_t c;
    rd_t r;
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      cmdq.delete(); rdq.delete(); last_a = '0;
    end else begin
      if (cmdq.size() > 0 && cmdq[0].due <= cyc) begin
        c = cmdq.pop_front();
        chk("mem_en", 32'(mem_en), 1);
        chk("mem_we", 32'(mem_we), 32'(c.w));
        chk("mem_addr", 32'(mem_addr), 32'(c.a));
        if (c.w) chk("mem_wdata", 32'(mem_wdata), 32'(c.d));
        last_a = c.a;
      end else begin
        chk("mem_en_idle", 32'(mem_en), 0);
        chk("mem_addr_hold", 32'(mem_addr), 32'(last_a));
      end
      if (rdq.size() > 0 && rdq[0].due <= cyc) begin
        r = rdq.pop_front();
        chk("rvalid", 32'(rvalid), 32'(1 << r.id));
        chk("rdata", 32'(rdata), 32'(r.d));
      end else begin
        chk("rvalid_idle", 32'(rvalid), 0);
      end
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (cq0.size() == 0 && cq1.size() == 0 && cq2.size() == 0 && req == 3'b000) return;
    end
    errors++;
    $display("FAIL wait_idle: clients still pending after %0d cycles", budget);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #2;
  endtask

  initial begin : main
    int idx;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    ram[32'h00100] = 12'hABC;
    shadow[32'h00100] = 12'hABC;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Display-only read of preloaded word.
    push(0, 0, 17'h00100, 12'h000);
    wait_idle(20); drain();

    // All three requesting; display has two requests.
    glog.delete();
    push(0, 0, 17'h00010, 0); push(0, 0, 17'h00011, 0);
    push(1, 0, 17'h00020, 0); push(2, 0, 17'h00030, 0);
    wait_idle(20); drain();
    chk("order_len", 32'(glog.size()), 4);
    if (glog.size() == 4) begin
      chk("order0", 32'(glog[0]), 0); chk("order1", 32'(glog[1]), 0);
      chk("order2", 32'(glog[2]), 1); chk("order3", 32'(glog[3]), 2);
    end

    // Write at max address, read back from the other draw client.
    push(1, 1, 17'h1FFFF, 12'h5A5);
    wait_idle(20);
    push(2, 0, 17'h1FFFF, 12'h000);
    wait_idle(20); drain();

    // Display with we set still reads.
    push(0, 1, 17'h00100, 12'h123);
    wait_idle(20); drain();

    // Display and client 1 requesting continuously.
    glog.delete();
    for (int k = 0; k < 20; k++) push(0, 0, 17'(k), 0);
    push(1, 0, 17'h00100, 0);
    wait_idle(100); drain();
    idx = -1;
    foreach (glog[i]) if (glog[i] == 1 && idx < 0) idx = i;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    chk("starve_grant_pos", 32'(idx), 16);
    if (glog.size() > 17) chk("disp_resumes", 32'(glog[17]), 0);
`else
    chk("strict_prio_pos", 32'(idx), 20);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      for (int c = 0; c < 3; c++) begin
        int qs;
        qs = (c == 0) ? cq0.size() : ((c == 1) ? cq1.size() : cq2.size());
        if (qs < 2 && $urandom_range(0, 3) == 0)
          push(c, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 15)),
               12'($urandom));
      end
    end
    wait_idle(3000); drain();

    // Reset pulse one cycle after a read grant.
    push(2, 0, 17'h00003, 0);
    wait_idle(20);
    rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    drain();
    push(1, 0, 17'h00100, 0);
    wait_idle(20); drain();
    chk("sb_cmd_empty", 32'(cmdq.size()), 0);
    chk("sb_rd_empty", 32'(rdq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
